// File: rtl/onehot_index_encoder_pkg.sv
// Shared definitions for the one-hot/index encoder family: FSM state type and
// an elaboration-time clog2 helper.
package onehot_index_encoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_index_encoder_if.sv
// Bitmap-in / index-out handshake bundle. master = producer/consumer side,
// slave = encoder side.
interface onehot_index_encoder_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
);
  logic [N-1:0] in_vec;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] idx_out;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         zero_drop;

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, idx_out, out_valid, out_last, zero_drop
  );

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, idx_out, out_valid, out_last, zero_drop
  );
endinterface

// File: rtl/onehot_index_encoder_priority_encoder.sv
// Combinational priority encoder: index of the first set bit (LSB- or
// MSB-first), plus any-set and exactly-one-set flags.
module priority_encoder
  import onehot_index_encoder_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned W         = 3,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         onehot
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Later matches overwrite earlier ones, so scan direction sets priority.
  always_comb begin
    idx = '0;
    if (LSB_FIRST != 0) begin
      for (int unsigned i = N; i > 0; i--) begin
        if (vec[i-1]) idx = W'(i - 1);
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  assign any    = |vec;
  assign onehot = any && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/onehot_index_encoder.sv
// Accepts an N-bit request bitmap and streams out one binary index per set
// bit in priority order; holds the pending register, FSM and handshakes.
module onehot_index_encoder
  import onehot_index_encoder_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned W         = 3,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  onehot_index_encoder_if.slave  bus
);
  if (N < 2 || N > 32) begin : g_bad_n
    $error("onehot_index_encoder: N=%0d out of range 2..32", N);
  end
  if (W != clog2(N)) begin : g_bad_w
    $error("onehot_index_encoder: W=%0d must equal clog2(N)=%0d", W, clog2(N));
  end

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         zero_drop_q, zero_drop_d;
  logic [W-1:0] pend_idx;
  logic         pend_any;
  logic         pend_onehot;

  priority_encoder #(
    .N         (N),
    .W         (W),
    .LSB_FIRST (LSB_FIRST)
  ) u_penc (
    .vec    (pending_q),
    .idx    (pend_idx),
    .any    (pend_any),
    .onehot (pend_onehot)
  );

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    zero_drop_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_vec != '0) begin
            pending_d = bus.in_vec;
            state_d   = ST_SCAN;
          end else begin
            zero_drop_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (bus.out_ready && pend_any) begin
          if (pend_onehot) begin
            pending_d = '0;
            state_d   = ST_IDLE;
          end else begin
            pending_d = pending_q & ~(ONE << pend_idx);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_drop_q <= zero_drop_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_SCAN);
  assign bus.idx_out   = pend_idx;
  assign bus.out_last  = pend_onehot;
  assign bus.zero_drop = zero_drop_q;

endmodule
